tag_fifo: RTL and testbench
===========================

# tag_fifo

Free-list of ROB tags feeding dispatch: holds every ROB tag not currently allocated, hands the oldest free tag to the dispatch stage (the value driven onto the ROB's `Dispatch_Rd_tag`, with `new_rd_tag_valid` qualified by `Tag_valid`), and takes tags back when the ROB retires an entry (`Retire_rd_tag`/`Retire_valid`). It sits directly upstream of the ROB, between retire and dispatch. A branch-mispredict flush returns every tag to the pool in one cycle.

## Interface
- `TAG_WIDTH`, 5, width of a ROB tag.
- `DEPTH`, 32, number of tags; must equal 2**TAG_WIDTH.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces the reset state immediately, independent of `clock`.
- `Flush` in 1: synchronous re-initialisation (mispredict recovery).
- `Tag_rd_en` in 1: dispatch consumes `Tag_out` this cycle (pop).
- `Tag_out` out TAG_WIDTH: tag at the head (show-ahead, combinational from storage).
- `Tag_valid` out 1: head is valid; equals (count != 0).
- `Retire_valid` in 1: a tag is being returned this cycle (push).
- `Retire_rd_tag` in TAG_WIDTH: tag being returned.
- `Tag_count` out TAG_WIDTH+1: number of free tags, 0..DEPTH.
- `Tag_full` out 1: count == DEPTH.
- `Tag_err` out 1: sticky protocol-error flag.

## Operation
- Storage: DEPTH x TAG_WIDTH register array, read pointer `rd_ptr`, write pointer `wr_ptr` (TAG_WIDTH bits, natural wrap at DEPTH-1 -> 0), counter `count` (TAG_WIDTH+1 bits).
- Reset state (async, also applied by `Flush` at the edge): mem[i] = i for i = 0..DEPTH-1; `rd_ptr`=0; `wr_ptr`=0; `count`=DEPTH. Outputs after reset: `Tag_out`=0, `Tag_valid`=1, `Tag_count`=32, `Tag_full`=1, `Tag_err`=0.
- `Flush` leaves `Tag_err` unchanged; only `reset` clears it.
- Pop effective = `Tag_rd_en` && count != 0. Effect: `rd_ptr`+1.
- Push effective = `Retire_valid` && (count != DEPTH || pop effective). Effect: mem[wr_ptr] <= `Retire_rd_tag`; `wr_ptr`+1.
- count update: +1 push only, -1 pop only, unchanged for both or neither.
- No bypass: push into an empty FIFO is not visible at `Tag_out` in the same cycle; pop when empty is ignored even if a push occurs that cycle.
- Full with simultaneous push and pop: both take effect; the popped head is read before the write to the same slot (rd_ptr == wr_ptr) lands.
- Error conditions: push refused (`Retire_valid` while full and no effective pop, meaning a duplicate free) or pop refused (`Tag_rd_en` while empty). Either sets `Tag_err` at the edge. Storage, pointers and count are unchanged by the refused operation.
- Priority at a clock edge: `reset` (async) > `Flush` > pop/push. `Retire_valid`/`Tag_rd_en` asserted with `Flush` are discarded and do not set `Tag_err`.
- The block does not check for duplicate tags beyond the full condition; retire/dispatch correctness is the ROB's responsibility.

## Timing
- `Tag_out`, `Tag_valid`, `Tag_full`, `Tag_count` are functions of registered state only. They change exactly one cycle after the edge that performs a pop, push or flush.
- Dispatch samples `Tag_out` in the same cycle it asserts `Tag_rd_en`. Sustained back-to-back pops deliver one new tag per cycle.
- Push-to-visible latency into an empty FIFO: the tag appears on `Tag_out` with `Tag_valid`=1 in the cycle after the pushing edge.
- `reset` asserted mid-operation takes effect combinationally: outputs reach reset values without waiting for a clock edge. Deassertion is synchronous to the next edge.

## Test plan
- Reset: assert `reset` for 1 cycle -> `Tag_out`=0, `Tag_valid`=1, `Tag_count`=32, `Tag_full`=1, `Tag_err`=0.
- Drain: hold `Tag_rd_en`=1 for 32 cycles -> `Tag_out` sequence 0,1,...,31. Then `Tag_count`=0, `Tag_valid`=0; a 33rd pop sets `Tag_err`=1 and `Tag_count` stays 0.
- Refill from empty: push 7 then 3 on consecutive cycles -> `Tag_out`=7 one cycle after the first push, `Tag_count`=2. Pop once -> `Tag_out`=3, `Tag_count`=1.
- Full pop+push: from reset, `Tag_rd_en`=1 and `Retire_valid`=1 with tag 9 in the same cycle -> popped tag 0, `Tag_count` stays 32, `Tag_err`=0. After popping 31 more tags (1..31), `Tag_out`=9.
- Duplicate free: from reset, `Retire_valid`=1 alone -> `Tag_err`=1, `Tag_count`=32, `Tag_out`=0.
- Flush mid-stream: pop 5 tags (`Tag_out`=5, count 27), then `Flush`=1 with `Retire_valid`=1 -> next cycle `Tag_count`=32, `Tag_out`=0, `Tag_err` unchanged. Async `reset` mid-drain -> outputs return to reset values before the next edge.

Source files
------------

// File: rtl/tag_fifo.sv
// Free-list of ROB tags: hands the oldest free tag to dispatch, accepts tags back at retire.
// Flush and reset both restore the full pool {0..DEPTH-1} in order.
module tag_fifo #(
  parameter int TAG_WIDTH = 5,
  parameter int DEPTH     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Flush,
  input  logic                 Tag_rd_en,
  output logic [TAG_WIDTH-1:0] Tag_out,
  output logic                 Tag_valid,
  input  logic                 Retire_valid,
  input  logic [TAG_WIDTH-1:0] Retire_rd_tag,
  output logic [TAG_WIDTH:0]   Tag_count,
  output logic                 Tag_full,
  output logic                 Tag_err
);

  localparam logic [TAG_WIDTH:0] DEPTH_C = (TAG_WIDTH + 1)'(DEPTH);
  localparam logic [TAG_WIDTH:0] ZERO_C  = '0;

  logic [TAG_WIDTH-1:0] mem [DEPTH];
  logic [TAG_WIDTH-1:0] rd_ptr;
  logic [TAG_WIDTH-1:0] wr_ptr;
  logic [TAG_WIDTH:0]   count;

  logic pop_ok;
  logic push_ok;
  logic err_set;

  // A push into a full pool is only legal when the head leaves in the same cycle.
  assign pop_ok  = Tag_rd_en && (count != ZERO_C);
  assign push_ok = Retire_valid && ((count != DEPTH_C) || pop_ok);
  assign err_set = (Retire_valid && !push_ok) || (Tag_rd_en && !pop_ok);

  always_ff @(posedge clock or posedge reset) begin
    if (reset || Flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= TAG_WIDTH'(i);
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= DEPTH_C;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= Retire_rd_tag;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky: survives Flush so a duplicate free is not hidden by mispredict recovery.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Tag_err <= 1'b0;
    end else if (!Flush && err_set) begin
      Tag_err <= 1'b1;
    end
  end

  assign Tag_out   = mem[rd_ptr];
  assign Tag_valid = (count != ZERO_C);
  assign Tag_full  = (count == DEPTH_C);
  assign Tag_count = count;

endmodule

// File: tb/tb_tag_fifo.sv
// Self-checking bench for tag_fifo: directed scenarios plus randomized traffic
// compared against a queue-based model of the free-list.
module tb_tag_fifo;

  logic       clock;
  logic       reset;
  logic       Flush;
  logic       Tag_rd_en;
  logic [4:0] Tag_out;
  logic       Tag_valid;
  logic       Retire_valid;
  logic [4:0] Retire_rd_tag;
  logic [5:0] Tag_count;
  logic       Tag_full;
  logic       Tag_err;

  int n_checks = 0;
  int n_fail   = 0;

  int m_q[$];
  bit m_err;

  tag_fifo #(.TAG_WIDTH(5), .DEPTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .Flush         (Flush),
    .Tag_rd_en     (Tag_rd_en),
    .Tag_out       (Tag_out),
    .Tag_valid     (Tag_valid),
    .Retire_valid  (Retire_valid),
    .Retire_rd_tag (Retire_rd_tag),
    .Tag_count     (Tag_count),
    .Tag_full      (Tag_full),
    .Tag_err       (Tag_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset(input bit clear_err);
    m_q.delete();
    for (int i = 0; i < 32; i++) m_q.push_back(i);
    if (clear_err) m_err = 1'b0;
  endfunction

  // Free-list semantics: take oldest, append returned, reject overflow/underflow.
  function automatic void model_step(input bit fl, input bit rd, input bit rv, input int t);
    bit can_pop;
    bit can_push;
    if (fl) begin
      model_reset(1'b0);
      return;
    end
    can_pop  = rd && (m_q.size() > 0);
    can_push = rv && ((m_q.size() < 32) || can_pop);
    if ((rd && !can_pop) || (rv && !can_push)) m_err = 1'b1;
    if (can_pop) void'(m_q.pop_front());
    if (can_push) m_q.push_back(t);
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_count"}, int'(Tag_count), m_q.size());
    chk({tag, "_valid"}, int'(Tag_valid), int'(m_q.size() != 0));
    chk({tag, "_full"},  int'(Tag_full),  int'(m_q.size() == 32));
    chk({tag, "_err"},   int'(Tag_err),   int'(m_err));
    if (m_q.size() != 0) chk({tag, "_out"}, int'(Tag_out), m_q[0]);
  endtask

  // Called at a negedge; applies inputs for one rising edge and returns at the next negedge.
  task automatic cyc(input bit fl, input bit rd, input bit rv, input int t);
    Flush         = fl;
    Tag_rd_en     = rd;
    Retire_valid  = rv;
    Retire_rd_tag = t[4:0];
    @(posedge clock);
    model_step(fl, rd, rv, t);
    @(negedge clock);
    Flush        = 1'b0;
    Tag_rd_en    = 1'b0;
    Retire_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset(1'b1);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    Flush         = 1'b0;
    Tag_rd_en     = 1'b0;
    Retire_valid  = 1'b0;
    Retire_rd_tag = '0;
    m_err         = 1'b0;
    @(negedge clock);
    do_reset();

    // Reset values
    chk("rst_out", int'(Tag_out), 0);
    chk("rst_valid", int'(Tag_valid), 1);
    chk("rst_count", int'(Tag_count), 32);
    chk("rst_full", int'(Tag_full), 1);
    chk("rst_err", int'(Tag_err), 0);

    // Drain all 32 tags in order, then underflow
    for (int i = 0; i < 32; i++) begin
      chk("drain_out", int'(Tag_out), i);
      cyc(0, 1, 0, 0);
    end
    chk("drain_count", int'(Tag_count), 0);
    chk("drain_valid", int'(Tag_valid), 0);
    chk("drain_err0", int'(Tag_err), 0);
    cyc(0, 1, 0, 0);
    chk("under_err", int'(Tag_err), 1);
    chk("under_count", int'(Tag_count), 0);

    // Refill from empty, no bypass
    cyc(0, 0, 1, 7);
    chk("refill_out7", int'(Tag_out), 7);
    chk("refill_valid", int'(Tag_valid), 1);
    cyc(0, 0, 1, 3);
    chk("refill_count2", int'(Tag_count), 2);
    cyc(0, 1, 0, 0);
    chk("refill_out3", int'(Tag_out), 3);
    chk("refill_count1", int'(Tag_count), 1);
    // Pop on empty with a simultaneous push: pop ignored, push lands
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 21);
    chk("empty_pp_count", int'(Tag_count), 1);
    chk("empty_pp_out", int'(Tag_out), 21);
    check_state("refill");

    // Full with simultaneous pop and push
    @(negedge clock);
    do_reset();
    chk("fpp_head", int'(Tag_out), 0);
    cyc(0, 1, 1, 9);
    chk("fpp_count", int'(Tag_count), 32);
    chk("fpp_err", int'(Tag_err), 0);
    for (int i = 1; i < 32; i++) begin
      chk("fpp_seq", int'(Tag_out), i);
      cyc(0, 1, 0, 0);
    end
    chk("fpp_out9", int'(Tag_out), 9);

    // Duplicate free
    do_reset();
    cyc(0, 0, 1, 4);
    chk("dup_err", int'(Tag_err), 1);
    chk("dup_count", int'(Tag_count), 32);
    chk("dup_out", int'(Tag_out), 0);

    // Flush keeps sticky error
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 17);
    chk("flush_err_kept", int'(Tag_err), 1);
    chk("flush_count_e", int'(Tag_count), 32);

    // Flush mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    chk("mid_out5", int'(Tag_out), 5);
    chk("mid_count27", int'(Tag_count), 27);
    cyc(1, 0, 1, 12);
    chk("flush_count", int'(Tag_count), 32);
    chk("flush_out", int'(Tag_out), 0);
    chk("flush_err", int'(Tag_err), 0);

    // Async reset mid-drain, checked before any rising edge
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 30);
    chk("pre_ar_count", int'(Tag_count), 27);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_out", int'(Tag_out), 0);
    chk("ar_count", int'(Tag_count), 32);
    chk("ar_valid", int'(Tag_valid), 1);
    chk("ar_full", int'(Tag_full), 1);
    chk("ar_err", int'(Tag_err), 0);
    model_reset(1'b1);
    @(negedge clock);
    reset = 1'b0;
    check_state("post_ar");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit fl;
      bit rd;
      bit rv;
      int t;
      fl = ($urandom_range(99) == 0);
      rd = ($urandom_range(99) < 55);
      rv = ($urandom_range(99) < 50);
      t  = $urandom_range(31);
      if (m_q.size() != 0) chk("rnd_head", int'(Tag_out), m_q[0]);
      cyc(fl, rd, rv, t);
      check_state("rnd");
      if ($urandom_range(299) == 0) begin
        do_reset();
        check_state("rnd_rst");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
